// File: rtl/f_pc_ctrl_pkg.sv
// Shared constants for the fetch PC controller: default address map and redirect-FSM encoding.
// Also holds the fetch-address legality test used for the combinational adel_F flag.
package f_pc_ctrl_pkg;

   localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
   localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
   localparam logic [31:0] IMEM_LO_DEF    = 32'h0000_3000;
   localparam logic [31:0] IMEM_HI_DEF    = 32'h0000_6FFC;
   localparam logic [31:0] PC_STEP        = 32'd4;

   typedef enum logic {
      RUN  = 1'b0,
      PEND = 1'b1
   } pc_state_t;

   function automatic logic pc_illegal(input logic [31:0] pc,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
      return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
   endfunction

endpackage

// File: rtl/f_pc_ctrl_if.sv
// Redirect/stall inputs and fetch-address outputs between the pipeline control and the F stage.
// master drives the redirect requests; slave is the PC controller.
interface f_pc_ctrl_if;
   logic        stall;
   logic        Interrupt;
   logic        eret;
   logic [31:0] EPC;
   logic        br_valid;
   logic [31:0] br_target;
   logic [31:0] PC_F;
   logic        flush_D;
   logic        adel_F;
   logic        pend;

   modport master (
      output stall, Interrupt, eret, EPC, br_valid, br_target,
      input  PC_F, flush_D, adel_F, pend
   );

   modport slave (
      input  stall, Interrupt, eret, EPC, br_valid, br_target,
      output PC_F, flush_D, adel_F, pend
   );
endinterface

// File: rtl/f_pc_ctrl_pc_reg.sv
// 32-bit PC register: loads i_d on a rising edge when i_ld is high, one-cycle latency.
// Asynchronous active-low reset forces the parameter value; holds when i_ld is low.
module f_pc_reg #(
   parameter logic [31:0] RESET_VAL = 32'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_ld,
   input  logic [31:0] i_d,
   output logic [31:0] o_q
);

   logic [31:0] r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= RESET_VAL;
      end else if (i_ld) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/f_pc_ctrl.sv
// Fetch PC controller: next-PC select (interrupt > eret > pending redirect > branch > stall > +4), one-cycle update.
// A branch arriving under stall is parked in tgt_q until the stall releases; interrupts ignore stall.
module f_pc_ctrl
   import f_pc_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
   parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
   parameter logic [31:0] IMEM_LO    = IMEM_LO_DEF,
   parameter logic [31:0] IMEM_HI    = IMEM_HI_DEF
) (
   input  logic        clk,
   input  logic        reset,
   f_pc_ctrl_if.slave  bus
);

   pc_state_t   r_state;
   pc_state_t   w_next_state;
   logic [31:0] r_tgt;
   logic [31:0] w_tgt_d;
   logic [31:0] w_pc;
   logic [31:0] w_pc_d;
   logic [31:0] w_pc_plus4;
   logic        w_pc_ld;
   logic        w_eret_ok;

   assign w_pc_plus4 = w_pc + PC_STEP;
   assign w_eret_ok  = bus.eret && !bus.stall;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= RUN;
         r_tgt   <= 32'h0;
      end else begin
         r_state <= w_next_state;
         r_tgt   <= w_tgt_d;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_tgt_d      = r_tgt;
      w_pc_d       = w_pc_plus4;
      w_pc_ld      = 1'b0;
      if (bus.Interrupt) begin
         w_pc_d       = HANDLER_PC;
         w_pc_ld      = 1'b1;
         w_next_state = RUN;
         w_tgt_d      = 32'h0;
      end else if (w_eret_ok) begin
         w_pc_d       = bus.EPC;
         w_pc_ld      = 1'b1;
         w_next_state = RUN;
         w_tgt_d      = 32'h0;
      end else if (r_state == PEND) begin
         // Parked redirect wins over any new branch; it leaves only when the stall drops.
         if (!bus.stall) begin
            w_pc_d       = r_tgt;
            w_pc_ld      = 1'b1;
            w_next_state = RUN;
         end
      end else if (bus.br_valid) begin
         if (!bus.stall) begin
            w_pc_d  = bus.br_target;
            w_pc_ld = 1'b1;
         end else begin
            w_tgt_d      = bus.br_target;
            w_next_state = PEND;
         end
      end else if (!bus.stall) begin
         w_pc_ld = 1'b1;
      end
   end

   f_pc_reg #(
      .RESET_VAL (RESET_PC)
   ) u_pc_reg (
      .clk   (clk),
      .rst_n (reset),
      .i_ld  (w_pc_ld),
      .i_d   (w_pc_d),
      .o_q   (w_pc)
   );

   // Outputs are gated by reset so nothing leaks while the core is held.
   assign bus.PC_F    = w_pc;
   assign bus.flush_D = reset && (bus.Interrupt || w_eret_ok);
   assign bus.adel_F  = reset && pc_illegal(w_pc, IMEM_LO, IMEM_HI);
   assign bus.pend    = (r_state == PEND);

endmodule

// File: tb/tb_f_pc_ctrl.sv
// Self-checking bench for f_pc_ctrl: directed scenarios plus randomized traffic against a priority-rule model.
module tb_f_pc_ctrl;

   localparam logic [31:0] T_RESET   = 32'h0000_3000;
   localparam logic [31:0] T_HANDLER = 32'h0000_4180;
   localparam logic [31:0] T_LO      = 32'h0000_3000;
   localparam logic [31:0] T_HI      = 32'h0000_6FFC;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   f_pc_ctrl_if bus ();

   f_pc_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int          errors = 0;
   int          checks = 0;
   logic [31:0] m_pc   = T_RESET;
   logic [31:0] m_tgt  = 32'h0;
   bit          m_pend = 1'b0;

   function automatic bit exp_adel(input logic [31:0] pc);
      return (pc % 4 != 0) || (pc < T_LO) || (pc > T_HI);
   endfunction

   function automatic bit exp_flush();
      return bus.Interrupt || (bus.eret && !bus.stall);
   endfunction

   task automatic drive(input bit st, input bit it, input bit er, input logic [31:0] epc,
                        input bit bv, input logic [31:0] bt);
      bus.stall = st; bus.Interrupt = it; bus.eret = er; bus.EPC = epc;
      bus.br_valid = bv; bus.br_target = bt;
      #1;
   endtask

   // Reference model: apply the redirect priority list once per rising edge.
   task automatic tick();
      @(posedge clk);
      if (reset) begin
         if (bus.Interrupt) begin
            m_pc = T_HANDLER; m_pend = 0; m_tgt = 0;
         end else if (bus.eret && !bus.stall) begin
            m_pc = bus.EPC; m_pend = 0; m_tgt = 0;
         end else if (m_pend) begin
            if (!bus.stall) begin m_pc = m_tgt; m_pend = 0; end
         end else if (bus.br_valid) begin
            if (!bus.stall) m_pc = bus.br_target;
            else begin m_tgt = bus.br_target; m_pend = 1; end
         end else if (!bus.stall) begin
            m_pc = m_pc + 32'd4;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive(0, 1, 1, 32'h3020, 1, 32'h5000);
      checks++; if (bus.PC_F !== T_RESET) begin errors++; $display("FAIL reset_pc got %h want %h", bus.PC_F, T_RESET); end
      checks++; if (bus.pend !== 1'b0) begin errors++; $display("FAIL reset_pend got %b want 0", bus.pend); end
      checks++; if (bus.flush_D !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", bus.flush_D); end
      checks++; if (bus.adel_F !== 1'b0) begin errors++; $display("FAIL reset_adel got %b want 0", bus.adel_F); end
      tick();
      checks++; if (bus.PC_F !== T_RESET) begin errors++; $display("FAIL reset_hold got %h want %h", bus.PC_F, T_RESET); end
      drive(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_sequential();
      reset = 1'b1; m_pc = T_RESET; m_pend = 0; m_tgt = 0;
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (bus.PC_F !== 32'h3000) begin errors++; $display("FAIL seq_start got %h want 3000", bus.PC_F); end
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++; if (bus.PC_F !== 32'h3000 + 4 * i) begin errors++; $display("FAIL seq_pc%0d got %h want %h", i, bus.PC_F, 32'h3000 + 4 * i); end
         checks++; if (bus.adel_F !== 1'b0) begin errors++; $display("FAIL seq_adel%0d got %b want 0", i, bus.adel_F); end
      end
   endtask

   task automatic test_branch_pend();
      tick();
      checks++; if (bus.PC_F !== 32'h3010) begin errors++; $display("FAIL pend_pre got %h want 3010", bus.PC_F); end
      drive(1, 0, 0, 0, 1, 32'h3100);
      checks++; if (bus.flush_D !== 1'b0) begin errors++; $display("FAIL pend_flush got %b want 0", bus.flush_D); end
      tick();
      for (int i = 0; i < 3; i++) begin
         // Two more stalled cycles carrying a competing branch, then the release cycle.
         if (i < 2) drive(1, 0, 0, 0, 1, 32'h3200);
         else       drive(0, 0, 0, 0, 0, 0);
         checks++; if (bus.pend !== 1'b1) begin errors++; $display("FAIL pend_flag%0d got %b want 1", i, bus.pend); end
         checks++; if (bus.PC_F !== 32'h3010) begin errors++; $display("FAIL pend_hold%0d got %h want 3010", i, bus.PC_F); end
         tick();
      end
      checks++; if (bus.PC_F !== 32'h3100) begin errors++; $display("FAIL pend_redirect got %h want 3100", bus.PC_F); end
      checks++; if (bus.pend !== 1'b0) begin errors++; $display("FAIL pend_clear got %b want 0", bus.pend); end
   endtask

   task automatic test_int_in_pend();
      drive(1, 0, 0, 0, 1, 32'h3100);
      tick();
      drive(1, 1, 0, 0, 0, 0);
      checks++; if (bus.flush_D !== 1'b1) begin errors++; $display("FAIL int_flush got %b want 1", bus.flush_D); end
      tick();
      checks++; if (bus.PC_F !== T_HANDLER) begin errors++; $display("FAIL int_pc got %h want %h", bus.PC_F, T_HANDLER); end
      checks++; if (bus.pend !== 1'b0) begin errors++; $display("FAIL int_pend got %b want 0", bus.pend); end
      drive(0, 0, 0, 0, 0, 0);
      tick();
      checks++; if (bus.PC_F !== T_HANDLER + 4) begin errors++; $display("FAIL int_discard got %h want %h", bus.PC_F, T_HANDLER + 4); end
   endtask

   task automatic test_eret();
      drive(0, 0, 1, 32'h3020, 0, 0);
      checks++; if (bus.flush_D !== 1'b1) begin errors++; $display("FAIL eret_flush got %b want 1", bus.flush_D); end
      tick();
      checks++; if (bus.PC_F !== 32'h3020) begin errors++; $display("FAIL eret_pc got %h want 3020", bus.PC_F); end
      drive(1, 0, 1, 32'h3040, 0, 0);
      checks++; if (bus.flush_D !== 1'b0) begin errors++; $display("FAIL eret_stall_flush got %b want 0", bus.flush_D); end
      tick();
      checks++; if (bus.PC_F !== 32'h3020) begin errors++; $display("FAIL eret_stall_pc got %h want 3020", bus.PC_F); end
      drive(0, 1, 1, 32'h3040, 0, 0);
      tick();
      checks++; if (bus.PC_F !== T_HANDLER) begin errors++; $display("FAIL int_eret got %h want %h", bus.PC_F, T_HANDLER); end
   endtask

   task automatic test_adel();
      logic [31:0] tgts [5];
      bit          want [5];
      tgts = '{32'h3002, 32'h7000, 32'h3000, 32'h2FFC, 32'h6FFC};
      want = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0, 0, 1, tgts[i]);
         checks++; if (bus.flush_D !== 1'b0) begin errors++; $display("FAIL adel_flush%0d got %b want 0", i, bus.flush_D); end
         tick();
         checks++; if (bus.PC_F !== tgts[i]) begin errors++; $display("FAIL adel_pc%0d got %h want %h", i, bus.PC_F, tgts[i]); end
         checks++; if (bus.adel_F !== want[i]) begin errors++; $display("FAIL adel_flag%0d got %b want %b", i, bus.adel_F, want[i]); end
      end
   endtask

   task automatic test_wrap();
      drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      tick();
      checks++; if (bus.PC_F !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h want 0", bus.PC_F); end
      checks++; if (bus.adel_F !== 1'b1) begin errors++; $display("FAIL wrap_adel got %b want 1", bus.adel_F); end
      drive(0, 0, 0, 0, 1, 32'h3000);
      tick();
   endtask

   task automatic test_random();
      logic [31:0] bt, epc;
      for (int n = 0; n < 400; n++) begin
         bt  = ($urandom_range(0, 7) == 0) ? $urandom : (32'h3000 + ($urandom_range(0, 4095) << 2));
         epc = ($urandom_range(0, 7) == 0) ? $urandom : (32'h3000 + ($urandom_range(0, 4095) << 2));
         drive($urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 12) == 0,
               epc, $urandom_range(0, 3) == 0, bt);
         checks++; if (bus.flush_D !== exp_flush()) begin errors++; $display("FAIL rnd_flush n=%0d got %b want %b", n, bus.flush_D, exp_flush()); end
         checks++; if (bus.PC_F !== m_pc) begin errors++; $display("FAIL rnd_pc n=%0d got %h want %h", n, bus.PC_F, m_pc); end
         checks++; if (bus.pend !== m_pend) begin errors++; $display("FAIL rnd_pend n=%0d got %b want %b", n, bus.pend, m_pend); end
         checks++; if (bus.adel_F !== exp_adel(m_pc)) begin errors++; $display("FAIL rnd_adel n=%0d got %b want %b", n, bus.adel_F, exp_adel(m_pc)); end
         tick();
      end
   endtask

   task automatic test_async_reset();
      drive(1, 0, 0, 0, 1, 32'h3500);
      tick();
      checks++; if (bus.pend !== 1'b1) begin errors++; $display("FAIL ar_pre_pend got %b want 1", bus.pend); end
      drive(1, 0, 0, 0, 0, 0);
      #2 reset = 1'b0;
      #1;
      checks++; if (bus.PC_F !== T_RESET) begin errors++; $display("FAIL ar_pc got %h want %h", bus.PC_F, T_RESET); end
      checks++; if (bus.pend !== 1'b0) begin errors++; $display("FAIL ar_pend got %b want 0", bus.pend); end
      m_pc = T_RESET; m_pend = 0; m_tgt = 0;
      @(negedge clk);
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      tick();
      checks++; if (bus.PC_F !== T_RESET + 4) begin errors++; $display("FAIL ar_first got %h want %h", bus.PC_F, T_RESET + 4); end
      checks++; if (bus.pend !== 1'b0) begin errors++; $display("FAIL ar_no_stale got %b want 0", bus.pend); end
   endtask

   initial begin
      bus.stall = 0; bus.Interrupt = 0; bus.eret = 0; bus.EPC = 0;
      bus.br_valid = 0; bus.br_target = 0;
      @(negedge clk);
      test_reset();
      test_sequential();
      test_branch_pend();
      test_int_in_pend();
      test_eret();
      test_adel();
      test_wrap();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running want finished");
      $fatal(1);
   end

endmodule

// File: doc/f_pc_ctrl.md
F_PC_CTRL -- requirements
Module: f_pc_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, is the fetch address after reset.
REQ-002 Parameter HANDLER_PC, default 32'h0000_4180, is the exception/interrupt entry address.
REQ-003 Parameters IMEM_LO/IMEM_HI, default 32'h0000_3000/32'h0000_6FFC, bound the legal fetch range (inclusive).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 stall  input  1  hazard unit freezes F (PC holds).
REQ-007 Interrupt  input  1  CP0 requests handler entry (interrupt or exception) this cycle.
REQ-008 eret  input  1  eret decoded in D this cycle.
REQ-009 EPC  input  32  CP0 return address.
REQ-010 br_valid  input  1  D-stage branch/jump taken this cycle.
REQ-011 br_target  input  32  D-stage branch/jump target.
REQ-012 PC_F  output  32  current fetch address.
REQ-013 flush_D  output  1  clear F/D register at next edge.
REQ-014 adel_F  output  1  fetch address misaligned or out of range.
REQ-015 pend  output  1  a redirect is latched awaiting stall release.

Function
REQ-016 Next-PC priority, highest first: Interrupt -> HANDLER_PC; eret -> EPC; PEND state -> latched target; br_valid -> br_target; stall -> hold; else PC_F + 4.
REQ-017 Interrupt SHALL load HANDLER_PC at the next edge regardless of stall, and SHALL assert flush_D combinationally in that cycle.
REQ-018 eret SHALL load EPC at the next edge if stall is low, and SHALL assert flush_D in that cycle.
REQ-019 eret with stall high SHALL be ignored; D holds eret, so it re-presents next cycle.
REQ-020 br_valid with stall low SHALL load br_target at the next edge; flush_D SHALL stay low (delay slot preserved).
REQ-021 br_valid with stall high SHALL latch br_target into tgt_q and move FSM RUN -> PEND; PC_F holds.
REQ-022 In PEND with stall low, PC_F SHALL load tgt_q at the next edge; FSM -> RUN.
REQ-023 In PEND with stall high, PC_F and tgt_q SHALL hold; a new br_valid SHALL be ignored.
REQ-024 Interrupt or eret accepted in PEND SHALL discard tgt_q; FSM -> RUN.
REQ-025 Output pend SHALL be 1 exactly when FSM is in PEND.
REQ-026 PC_F + 4 SHALL wrap modulo 2^32 without flagging.
REQ-027 adel_F SHALL be combinational: PC_F[1:0] != 0, or PC_F < IMEM_LO, or PC_F > IMEM_HI.
REQ-028 An illegal PC SHALL still be loaded unmodified; low bits SHALL not be masked, so EPC capture stays exact.
REQ-029 Interrupt and eret together SHALL resolve as Interrupt.

Reset
REQ-030 While reset is low: PC_F = RESET_PC, FSM = RUN, tgt_q = 0, flush_D = 0, pend = 0, adel_F = 0.
REQ-031 Reset assertion mid-PEND SHALL discard the latched target immediately, without waiting for clk.
REQ-032 After reset deasserts, the first edge SHALL apply the normal priority rules starting from RESET_PC.

Structure
REQ-033 RESET_PC, HANDLER_PC, IMEM_LO and IMEM_HI defaults SHALL live in the shared const header; the FSM state encoding (RUN = 1'b0, PEND = 1'b1) SHALL be declared there.
REQ-034 One sub-module, f_pc_reg (32-bit register with asynchronous active-low reset to a parameter value and a load enable), SHALL hold PC_F; all other logic stays in f_pc_ctrl.

Verification
REQ-035 Release reset, all inputs 0, run 3 cycles -> PC_F = 0x3000, 0x3004, 0x3008, 0x300C; adel_F = 0.
REQ-036 At PC_F = 0x3010: stall = 1 and br_valid = 1 (target 0x3100) for 1 cycle, then stall held 2 more cycles, then released -> pend = 1 for 3 cycles, PC_F = 0x3010 throughout, then 0x3100.
REQ-037 In PEND, pulse Interrupt with stall = 1 -> next PC_F = 0x4180, flush_D = 1 in the Interrupt cycle, pend = 0; target 0x3100 never fetched.
REQ-038 EPC = 0x3020, eret = 1, stall = 0 -> next PC_F = 0x3020 with flush_D = 1; repeat with stall = 1 -> PC_F holds.
REQ-039 br_valid with target 0x3002, then 0x7000 -> PC_F loads each value unmodified and adel_F = 1 for each; br_valid with target 0x3000 -> adel_F = 0.
REQ-040 Drop reset asynchronously mid-cycle while in PEND -> PC_F = 0x3000 and pend = 0 before the next clk edge.
